// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg: shared state encoding and port ids for the data-memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2: combinational two-request picker (round-robin or fixed priority)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  input  logic       fixed_prio,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = PORT0;
    if (fixed_prio) begin
      winner = req[0] ? PORT0 : PORT1;
    end else if (&req) begin
      // Tie: the pointer names the port whose turn it is.
      winner = pointer;
    end else begin
      winner = req[1] ? PORT1 : PORT0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter: shares a single-port 32-word data memory between two requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_ack0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  state_t                state;
  state_t                next_state;
  logic                  ptr;
  logic                  grant_id;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  win_id;
  logic                  win_valid;

  rr_arb2 u_arb (
    .req        ({i_req1, i_req0}),
    .pointer    (ptr),
    .fixed_prio (FIXED_PRIO != 0),
    .winner     (win_id),
    .valid      (win_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (win_valid) next_state = ST_ACCESS;
      ST_ACCESS: next_state = ST_ACK;
      ST_ACK:    next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr       <= PORT0;
      grant_id  <= PORT0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      o_ack0    <= 1'b0;
      o_ack1    <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      // Acks are single-cycle: set at the ACCESS edge, cleared at the ACK edge.
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant_id  <= win_id;
            lat_we    <= (win_id == PORT1) ? i_we1    : i_we0;
            lat_addr  <= (win_id == PORT1) ? i_addr1  : i_addr0;
            lat_wdata <= (win_id == PORT1) ? i_wdata1 : i_wdata0;
            ptr       <= ~win_id;
          end
        end
        ST_ACCESS: begin
          if (grant_id == PORT1) begin
            o_ack1 <= 1'b1;
            if (!lat_we) o_rdata1 <= i_mem_rdata;
          end else begin
            o_ack0 <= 1'b1;
            if (!lat_we) o_rdata0 <= i_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset during ACCESS must not let the write commit.
  assign o_mem_we    = (state == ST_ACCESS) & lat_we & ~i_rst;
  assign o_mem_addr  = lat_addr;
  assign o_mem_wdata = lat_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter: self-checking bench, round-robin and fixed-priority instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, preload;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;

  logic        ack0_a, ack1_a, mwe_a, ack0_b, ack1_b, mwe_b;
  logic [31:0] rdata0_a, rdata1_a, mwdata_a, mrdata_a;
  logic [31:0] rdata0_b, rdata1_b, mwdata_b, mrdata_b;
  logic [4:0]  maddr_a, maddr_b;

  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];

  int n_chk = 0;
  int n_fail = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(0)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0_a), .o_rdata0(rdata0_a),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1_a), .o_rdata1(rdata1_a),
    .o_mem_addr(maddr_a), .o_mem_wdata(mwdata_a), .o_mem_we(mwe_a),
    .i_mem_rdata(mrdata_a)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0_b), .o_rdata0(rdata0_b),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1_b), .o_rdata1(rdata1_b),
    .o_mem_addr(maddr_b), .o_mem_wdata(mwdata_b), .o_mem_we(mwe_b),
    .i_mem_rdata(mrdata_b)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 7) ? 32'h7777_7777 : (i == 9) ? 32'h9999_9999 : 32'h0;
  endfunction

  // Memory models: asynchronous read, write on the rising edge.
  assign mrdata_a = mem_a[maddr_a];
  assign mrdata_b = mem_b[maddr_b];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (mwe_a) mem_a[maddr_a] <= mwdata_a;
      if (mwe_b) mem_b[maddr_b] <= mwdata_b;
    end
  end

  typedef struct {
    logic        rst;
    logic        req0;
    logic        we0;
    logic [4:0]  addr0;
    logic [31:0] wd0;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_mwe;
    logic [4:0]  e_maddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic q, input logic w,
                              input logic [4:0] a, input logic [31:0] d,
                              input logic ea, input logic [31:0] erd,
                              input logic emwe, input logic [4:0] ema);
    vec_t v;
    v.rst = r; v.req0 = q; v.we0 = w; v.addr0 = a; v.wd0 = d;
    v.e_ack0 = ea; v.e_ack1 = 1'b0; v.e_rd0 = erd; v.e_rd1 = 32'h0;
    v.e_mwe = emwe; v.e_maddr = ema;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, last, nb0, nb1;
    logic got, got0, got1;

    // One row per cycle: inputs during the cycle and outputs seen in it.
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0);
    tbl[1]  = mk(0, 1, 1, 5, 32'hDEADBEEF,   0, 32'h0,          0, 0);
    tbl[2]  = mk(0, 1, 1, 5, 32'hDEADBEEF,   0, 32'h0,          1, 5);
    tbl[3]  = mk(0, 1, 1, 5, 32'hDEADBEEF,   1, 32'h0,          0, 5);
    tbl[4]  = mk(0, 1, 0, 5, 32'h0,          0, 32'h0,          0, 5);
    tbl[5]  = mk(0, 1, 0, 5, 32'h0,          0, 32'h0,          0, 5);
    tbl[6]  = mk(0, 1, 0, 5, 32'h0,          1, 32'hDEADBEEF,   0, 5);
    tbl[7]  = mk(0, 1, 0, 7, 32'h0,          0, 32'hDEADBEEF,   0, 5);
    tbl[8]  = mk(0, 1, 0, 9, 32'h0,          0, 32'hDEADBEEF,   0, 7);
    tbl[9]  = mk(0, 1, 0, 9, 32'h0,          1, 32'h7777_7777,  0, 7);
    tbl[10] = mk(0, 1, 1, 3, 32'h1234_5678,  0, 32'h7777_7777,  0, 7);
    tbl[11] = mk(1, 1, 1, 3, 32'h1234_5678,  0, 32'h7777_7777,  0, 3);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0);
    tbl[13] = mk(0, 1, 0, 3, 32'h0,          0, 32'h0,          0, 0);
    tbl[14] = mk(0, 1, 0, 3, 32'h0,          0, 32'h0,          0, 3);
    tbl[15] = mk(0, 1, 0, 3, 32'h0,          1, 32'h0,          0, 3);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 3);

    preload = 1'b1; rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    for (int k = 0; k < 17; k++) begin
      rst = tbl[k].rst; req0 = tbl[k].req0; we0 = tbl[k].we0;
      addr0 = tbl[k].addr0; wdata0 = tbl[k].wd0;
      #1;
      chk($sformatf("row%0d_ack0", k),   {31'h0, ack0_a},  {31'h0, tbl[k].e_ack0});
      chk($sformatf("row%0d_ack1", k),   {31'h0, ack1_a},  {31'h0, tbl[k].e_ack1});
      chk($sformatf("row%0d_rdata0", k), rdata0_a,         tbl[k].e_rd0);
      chk($sformatf("row%0d_rdata1", k), rdata1_a,         tbl[k].e_rd1);
      chk($sformatf("row%0d_mem_we", k), {31'h0, mwe_a},   {31'h0, tbl[k].e_mwe});
      chk($sformatf("row%0d_mem_addr", k), {27'h0, maddr_a}, {27'h0, tbl[k].e_maddr});
      @(posedge clk);
      #1;
    end

    // Both ports read continuously from reset.
    rst = 1; req0 = 0; req1 = 0;
    tick();
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 7;
    req1 = 1; we1 = 0; addr1 = 9;
    n = 0; last = 0; nb0 = 0; nb1 = 0;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      tick();
      if (ack0_b) nb0++;
      if (ack1_b) nb1++;
      if (ack0_a || ack1_a) begin
        if (n == 0) chk("rr_first_latency", c, 2);
        else        chk("rr_ack_spacing", c - last, 3);
        chk("rr_grant_port", {31'h0, ack1_a}, n % 2);
        chk("rr_single_ack", {31'h0, ack0_a & ack1_a}, 0);
        chk("rr_rdata", ack1_a ? rdata1_a : rdata0_a,
            ack1_a ? 32'h9999_9999 : 32'h7777_7777);
        last = c;
        n++;
      end
    end
    chk("rr_grants", n, 8);
    chk("fp_port0_acks", nb0, 8);
    chk("fp_port1_acks", nb1, 0);

    // Port 0 backs off: the fixed-priority instance finally serves port 1.
    req0 = 0;
    got = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      tick();
      if (ack0_b) chk("fp_no_port0_ack", {31'h0, ack0_b}, 0);
      if (ack1_b) begin
        got = 1;
        chk("fp_port1_latency", c, 3);
        chk("fp_port1_rdata", rdata1_b, 32'h9999_9999);
        chk("rr_port1_alone", {31'h0, ack1_a}, 1);
      end
    end
    chk("fp_port1_served", {31'h0, got}, 1);
    req1 = 0;
    tick();

    // Move the pointer to port 1, then collide a port-1 write with a port-0 read.
    rst = 1;
    tick();
    rst = 0; req0 = 1; we0 = 0; addr0 = 0;
    got = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      tick();
      if (ack0_a) got = 1;
    end
    chk("t4_setup_ack", {31'h0, got}, 1);
    req0 = 0;
    tick();
    req0 = 1; we0 = 0; addr0 = 31; wdata0 = 0;
    req1 = 1; we1 = 1; addr1 = 31; wdata1 = 32'h0000_00A5;
    got0 = 0; got1 = 0;
    for (int c = 1; c <= 20 && !got0; c++) begin
      tick();
      if (ack1_a && !got1) begin
        got1 = 1;
        chk("t4_port1_first", {31'h0, got0}, 0);
        chk("t4_rdata1_hold", rdata1_a, 32'h0);
        req1 = 0;
      end
      if (ack0_a && !got0) begin
        got0 = 1;
        chk("t4_port0_second", {31'h0, got1}, 1);
        chk("t4_rdata0", rdata0_a, 32'h0000_00A5);
        req0 = 0;
      end
    end
    chk("t4_both_acked", {31'h0, got0 & got1}, 1);
    req0 = 0; req1 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port, 32-word data memory between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug port). Each access is latched, issued to the memory for exactly one cycle, and answered with a one-cycle acknowledge carrying the read data. The block sits between the requesters and the data memory. It drives the memory address, write-data and write-enable, and samples the memory's asynchronous read output.

Parameters:
DATA_WIDTH, 32, width of data words on all ports
ADDR_WIDTH, 5, word address width (32 words)
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_req0  input  1  port 0 request; held high with stable addr/we/wdata until o_ack0
i_we0  input  1  port 0 write (1) / read (0)
i_addr0  input  ADDR_WIDTH  port 0 word address
i_wdata0  input  DATA_WIDTH  port 0 write data
o_ack0  output  1  port 0 completion pulse, one cycle
o_rdata0  output  DATA_WIDTH  port 0 read data, valid while o_ack0=1 on reads
i_req1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1  same as port 0, for port 1
o_mem_addr  output  ADDR_WIDTH  to memory address
o_mem_wdata  output  DATA_WIDTH  to memory write data
o_mem_we  output  1  to memory write enable
i_mem_rdata  input  DATA_WIDTH  asynchronous memory read data

Behaviour:
- Reset values: state=IDLE, priority pointer=port 0, o_ack0/1=0, o_rdata0/1=0, latched addr/wdata/we=0, o_mem_we=0.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE: if any request is high, the winner is chosen. Winner's addr/we/wdata and port id are latched; next state is ACCESS. No request: stay in IDLE.
- Arbitration, FIXED_PRIO=1: port 0 wins whenever i_req0=1.
- Arbitration, FIXED_PRIO=0: a single requester wins. On a tie, the port indicated by the pointer wins; after each grant the pointer moves to the other port.
- ACCESS (exactly 1 cycle): o_mem_addr and o_mem_wdata = latched values. o_mem_we = latched_we & ~i_rst.
- At the ACCESS edge: the write commits in memory. For reads, i_mem_rdata is registered into o_rdata of the granted port; for writes, o_rdata is unchanged. o_ack of the granted port is set. Next state is ACK.
- ACK (1 cycle): o_ack of the granted port is high. No arbitration. Next state is IDLE; o_ack clears at that edge.
- Latency: request seen in IDLE at cycle N → memory access at N+1 → ack at N+2. Minimum 3 cycles per access; peak throughput 1 access per 3 cycles.
- Requests are ignored in ACK, so a requester dropping req after ack is never re-served.
- o_mem_addr/o_mem_wdata are don't-care but driven with latched values outside ACCESS. o_mem_we=0 outside ACCESS.
- Requester changing addr/data before ack: no effect, values are already latched.
- o_rdata of the non-granted port holds its previous value.
- Reset in any state: next state is IDLE, acks clear. Reset asserted during ACCESS suppresses o_mem_we in that cycle, so no write commits and no ack is issued.
- Address is the full ADDR_WIDTH word index; there is no out-of-range case.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding constants: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2
  - port id constants: PORT0=1'b0, PORT1=1'b1
- Sub-module rr_arb2: combinational 2-request picker.
  - inputs: req[1:0], pointer, fixed_prio
  - output: winner id and valid
  - the pointer register stays in dmem_arbiter.

Test Plan:
- Port 0 writes 32'hDEADBEEF to addr 5, then reads addr 5 → o_mem_we high exactly one cycle (ACCESS), o_ack0 at request cycle+2, o_rdata0=32'hDEADBEEF.
- Ports 0 and 1 both request reads continuously from reset, FIXED_PRIO=0 → grants alternate 0,1,0,1; acks spaced 3 cycles apart; neither port is starved.
- Same stimulus with FIXED_PRIO=1 → port 0 is granted every time; port 1 is acked only after i_req0 drops.
- Port 1 writes 32'h0000_00A5 to addr 31 while port 0 simultaneously reads addr 31, round-robin pointer at port 1 → port 1 acked first; port 0 then reads 32'h0000_00A5.
- i_rst asserted during the ACCESS cycle of a write of 32'h12345678 to addr 3 (memory previously 0) → no o_ack; o_mem_we=0 that cycle; subsequent read of addr 3 returns 0; state back to IDLE.
- Port 0 changes i_addr0 from 7 to 9 during ACCESS → the memory access uses addr 7, and o_rdata0 reflects addr 7.
